// File: rtl/mux3_rr_sched.sv
// mux3_rr_sched
// Round-robin owner of a shared 3:1 datapath mux feeding one valid/ready
// stream. A requester keeps the mux for up to MAX_BURST accepted beats or
// until it drops its request. Every grant is followed by one idle cycle, and
// arbitration is only re-run from idle.
module mux3_rr_sched #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Beat count value at which the next transfer closes the burst.
    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     r_state;
    logic [1:0] r_sel;
    logic [2:0] r_gnt;
    logic [1:0] r_last;
    logic [3:0] r_cnt;

    logic [1:0]       w_cand0;
    logic [1:0]       w_cand1;
    logic [1:0]       w_cand2;
    logic             w_pick_valid;
    logic [1:0]       w_pick_idx;
    logic             w_owner_req;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_xfer;
    logic             w_last_beat;

    // Successor in the circular order 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Search order starts just after the last served requester and ends on it.
    assign w_cand0 = next_idx(r_last);
    assign w_cand1 = next_idx(w_cand0);
    assign w_cand2 = r_last;

    // Pick the first requesting candidate in round-robin order.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        w_pick_valid = 1'b1;
        w_pick_idx   = w_cand0;
        if (req[w_cand0]) begin
            w_pick_idx = w_cand0;
        end else if (req[w_cand1]) begin
            w_pick_idx = w_cand1;
        end else if (req[w_cand2]) begin
            w_pick_idx = w_cand2;
        end else begin
            w_pick_valid = 1'b0;
        end
    end

    // The 3:1 datapath mux plus the owner's request line, both steered by sel.
    always_comb begin
        w_owner_req = 1'b0;
        w_sel_data  = '0;
        case (r_sel)
            2'd0: begin
                w_owner_req = req[0];
                w_sel_data  = in_data0;
            end
            2'd1: begin
                w_owner_req = req[1];
                w_sel_data  = in_data1;
            end
            2'd2: begin
                w_owner_req = req[2];
                w_sel_data  = in_data2;
            end
            default: begin
                w_owner_req = 1'b0;
                w_sel_data  = '0;
            end
        endcase
    end

    assign out_valid   = (r_state == S_GRANT) && w_owner_req;
    assign out_data    = out_valid ? w_sel_data : '0;
    assign w_xfer      = out_valid && out_ready;
    assign w_last_beat = w_xfer && (r_cnt == LAST_CNT);

    // Arbitration FSM: grant from idle, count beats, release to idle.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_gnt   <= 3'b000;
            r_last  <= 2'd2;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_sel   <= w_pick_idx;
                        r_gnt   <= 3'b001 << w_pick_idx;
                        r_cnt   <= 4'd0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Owner release and burst exhaustion both end the grant;
                    // sel is left pointing at the last owner.
                    if (!w_owner_req || w_last_beat) begin
                        r_state <= S_IDLE;
                        r_last  <= r_sel;
                        r_gnt   <= 3'b000;
                        r_cnt   <= 4'd0;
                    end else if (w_xfer) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = (r_state == S_GRANT);

endmodule

// File: tb/tb_mux3_rr_sched.sv
// Bench for mux3_rr_sched: directed scenarios with hand-derived grant/beat
// logs, then randomized traffic compared every cycle to a behavioural model.
module tb_mux3_rr_sched;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       req = 3'b000;
    logic [WIDTH-1:0] din [3];
    logic             out_ready = 1'b0;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    mux3_rr_sched #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data0  (din[0]),
        .in_data1  (din[1]),
        .in_data2  (din[2]),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = -1 when nobody holds the mux; beats = transfers done in this grant.
    typedef struct {
        int owner;
        int beats;
        int last;
        int sel;
    } mstate_t;

    mstate_t m = '{owner: -1, beats: 0, last: 2, sel: 0};

    function automatic mstate_t model_step(input mstate_t s, input logic [2:0] r,
                                           input logic rdy, input logic rs);
        mstate_t n = s;
        if (rs) begin
            n = '{owner: -1, beats: 0, last: 2, sel: 0};
        end else if (s.owner < 0) begin
            for (int k = 1; k <= 3; k++) begin
                int idx = (s.last + k) % 3;
                if (r[idx] && n.owner < 0) begin
                    n.owner = idx;
                    n.sel   = idx;
                    n.beats = 0;
                end
            end
        end else if (!r[s.owner] || (rdy && s.beats + 1 == MAX_BURST)) begin
            n.last  = s.owner;
            n.owner = -1;
            n.beats = 0;
        end else if (rdy) begin
            n.beats = s.beats + 1;
        end
        return n;
    endfunction

    // {gnt, sel, busy, out_valid, out_data}
    function automatic logic [14:0] expect_outs(input mstate_t s, input logic [2:0] r,
                                                input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c);
        logic [2:0] g = 3'b000;
        logic       bz = (s.owner >= 0);
        logic       v = 1'b0;
        logic [7:0] d = 8'h00;
        if (bz) begin
            g = 3'(1 << s.owner);
            v = r[s.owner];
            if (v) d = (s.owner == 0) ? a : (s.owner == 1) ? b : c;
        end
        return {g, 2'(s.sel), bz, v, d};
    endfunction

    always @(posedge clk) m <= model_step(m, req, out_ready, rst);

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en)
            check("cycle", {gnt, sel, busy, out_valid, out_data},
                  expect_outs(m, req, din[0], din[1], din[2]));
    end

    // ---------------- stimulus ----------------
    int         rem [3];
    bit         auto_mode = 1'b0;
    bit         rand_mode = 1'b0;
    logic [2:0] prev_gnt  = 3'b000;
    int         log_owner [$];
    int         log_beats [$];

    // One clock: observe at the falling edge, update inputs just after the rising edge.
    task automatic tick();
        logic [2:0] acc;
        @(negedge clk);
        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
            log_owner.push_back(int'(sel));
            log_beats.push_back(0);
        end
        if (!rst && out_valid && out_ready && log_beats.size() > 0)
            log_beats[log_beats.size()-1]++;
        prev_gnt = gnt;
        acc = rst ? 3'b000 : (gnt & req & {3{out_ready}});
        @(posedge clk);
        #1;
        if (auto_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i] && rem[i] > 0) rem[i]--;
                req[i] = (rem[i] > 0);
            end
        end else if (rand_mode) begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i]) begin
                    din[i] = 8'($urandom);
                    req[i] = ($urandom_range(0, 3) != 0);
                end else if (req[i]) begin
                    req[i] = ($urandom_range(0, 15) != 0);
                end else begin
                    req[i] = ($urandom_range(0, 1) == 1);
                    din[i] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic apply_rem();
        for (int i = 0; i < 3; i++) req[i] = (rem[i] > 0);
    endtask

    task automatic do_reset();
        auto_mode = 1'b0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        req       = 3'b000;
        out_ready = 1'b0;
        tick();
        cmp_en = 1'b1;
        tick();
        rst = 1'b0;
        log_owner.delete();
        log_beats.delete();
    endtask

    task automatic check_log(input string name, input int eo [5], input int eb [5], input int n);
        check({name, "_grants"}, log_owner.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < log_owner.size()) begin
                check($sformatf("%s_owner%0d", name, i), log_owner[i], eo[i]);
                check($sformatf("%s_beats%0d", name, i), log_beats[i], eb[i]);
            end
        end
    endtask

    initial begin
        din[0] = 8'h10;
        din[1] = 8'h21;
        din[2] = 8'h32;

        // Reset with all requests high, then first grant goes to requester 0.
        rst = 1'b1;
        req = 3'b111;
        out_ready = 1'b1;
        tick();
        cmp_en = 1'b1;
        tick();
        check("rst_gnt", gnt, 3'b000);
        check("rst_sel", sel, 2'b00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_gnt", gnt, 3'b001);
        check("post_rst_busy", busy, 1'b1);

        // Burst limit: requester 1 alone with 6 beats.
        do_reset();
        rem = '{0, 6, 0};
        auto_mode = 1'b1;
        out_ready = 1'b1;
        apply_rem();
        repeat (15) tick();
        check_log("burst", '{1, 1, 0, 0, 0}, '{4, 2, 0, 0, 0}, 2);
        check("burst_done_req", req, 3'b000);

        // Fairness: everyone streaming, rotation 0,1,2,0,1.
        do_reset();
        rem = '{100, 100, 100};
        auto_mode = 1'b1;
        out_ready = 1'b1;
        apply_rem();
        repeat (26) tick();
        check_log("fair", '{0, 1, 2, 0, 1}, '{4, 4, 4, 4, 4}, 5);

        // Backpressure mid-burst on requester 2.
        do_reset();
        din[2] = 8'hA5;
        rem = '{0, 0, 4};
        auto_mode = 1'b1;
        out_ready = 1'b1;
        apply_rem();
        repeat (3) tick();
        out_ready = 1'b0;
        repeat (3) begin
            tick();
            check("bp_data", out_data, 8'hA5);
            check("bp_gnt", gnt, 3'b100);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        check_log("bp", '{2, 0, 0, 0, 0}, '{4, 0, 0, 0, 0}, 1);

        // Early release: requester 0 leaves after 2 beats, requester 1 follows.
        do_reset();
        rem = '{2, 3, 0};
        auto_mode = 1'b1;
        out_ready = 1'b1;
        apply_rem();
        repeat (12) tick();
        check_log("early", '{0, 1, 0, 0, 0}, '{2, 3, 0, 0, 0}, 2);

        // Reset after beat 2 of requester 1, then req=011 restarts at requester 0.
        do_reset();
        rem = '{0, 4, 0};
        auto_mode = 1'b1;
        out_ready = 1'b1;
        apply_rem();
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("midrst_outs", {gnt, sel, busy, out_valid, out_data}, 15'h0);
        rst = 1'b0;
        rem = '{3, 3, 0};
        apply_rem();
        tick();
        check("midrst_regrant", gnt, 3'b001);

        // Randomized traffic, checked every cycle by the model.
        do_reset();
        rand_mode = 1'b1;
        repeat (3000) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
